// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 single-bit mux: steps sel through channels 0..3, settles,
// samples y, and publishes the assembled 4-bit word with a one-cycle done strobe.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic [3:0]       ch_mask_i,
    input  logic             y_i,
    output logic [1:0]       sel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       word_o,
    output logic [CNT_W-1:0] scan_cnt_o
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic [3:0] SettleM1 = 4'(SETTLE - 1);

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         shadow_q, shadow_d;
    logic [3:0]         mask_q, mask_d;
    logic [3:0]         word_q, word_d;
    logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic               advance;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        mask_d     = mask_q;
        word_d     = word_q;
        scan_cnt_d = scan_cnt_q;
        advance    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mask_d   = ch_mask_i;
                    shadow_d = 4'b0000;
                    sel_d    = 2'd0;
                    cnt_d    = SettleM1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                // Masked channels skip settling and take a single cycle.
                if (!mask_q[sel_q]) begin
                    shadow_d[sel_q] = 1'b0;
                    advance         = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    shadow_d[sel_q] = y_i;
                    advance         = 1'b1;
                end

                if (advance) begin
                    if (sel_q != 2'd3) begin
                        sel_d = sel_q + 2'd1;
                        cnt_d = SettleM1;
                    end else begin
                        word_d     = shadow_d;
                        scan_cnt_d = scan_cnt_q + CNT_W'(1);
                        state_d    = StDone;
                    end
                end
            end
            StDone: begin
                sel_d = 2'd0;
                if (cont_i) begin
                    mask_d   = ch_mask_i;
                    shadow_d = 4'b0000;
                    cnt_d    = SettleM1;
                    state_d  = StWait;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            sel_q      <= 2'd0;
            cnt_q      <= 4'd0;
            shadow_q   <= 4'b0000;
            mask_q     <= 4'b0000;
            word_q     <= 4'b0000;
            scan_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            mask_q     <= mask_d;
            word_q     <= word_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    assign sel_o      = sel_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign word_o     = word_q;
    assign scan_cnt_o = scan_cnt_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3) beside a modelled 4:1 mux;
// expected words/counts are queued at scan start and popped on each done strobe.
module tb_mux_scan_ctrl;

    typedef struct packed {
        logic [3:0] word;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start3;
    logic       cont;
    logic [3:0] ch_mask;
    logic [3:0] mux_in;

    logic       y1, y3;
    logic [1:0] sel1, sel3;
    logic       busy1, busy3, done1, done3;
    logic [3:0] word1, word3;
    logic [7:0] cnt1, cnt3;

    exp_t       q1[$];
    exp_t       q3[$];
    logic [7:0] cnt1_m;
    logic [7:0] cnt3_m;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign y1 = mux_in[sel1];
    assign y3 = mux_in[sel3];

    mux_scan_ctrl #(.SETTLE(1), .CNT_W(8)) dut1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start1),
        .cont_i     (cont),
        .ch_mask_i  (ch_mask),
        .y_i        (y1),
        .sel_o      (sel1),
        .busy_o     (busy1),
        .done_o     (done1),
        .word_o     (word1),
        .scan_cnt_o (cnt1)
    );

    mux_scan_ctrl #(.SETTLE(3), .CNT_W(8)) dut3 (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start3),
        .cont_i     (1'b0),
        .ch_mask_i  (ch_mask),
        .y_i        (y3),
        .sel_o      (sel3),
        .busy_o     (busy3),
        .done_o     (done3),
        .word_o     (word3),
        .scan_cnt_o (cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done1(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done1 && n < budget);
        if (!done1) chk("done1_timeout", 32'(done1), 1);
    endtask

    task automatic push1(input logic [3:0] w);
        cnt1_m = cnt1_m + 8'd1;
        q1.push_back('{word: w, cnt: cnt1_m});
    endtask

    // Scoreboard: every done strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) begin
                chk("done1_unexpected", 32'(done1), 0);
            end else begin
                e = q1.pop_front();
                chk("word1", 32'(word1), 32'(e.word));
                chk("cnt1", 32'(cnt1), 32'(e.cnt));
            end
        end
        if (done3) begin
            if (q3.size() == 0) begin
                chk("done3_unexpected", 32'(done3), 0);
            end else begin
                e = q3.pop_front();
                chk("word3", 32'(word3), 32'(e.word));
                chk("cnt3", 32'(cnt3), 32'(e.cnt));
            end
        end
    end

    initial begin
        int n;
        int exp_sel3[8] = '{0, 0, 0, 1, 2, 2, 2, 3};

        cnt1_m  = 8'd0;
        cnt3_m  = 8'd0;
        rst     = 1'b1;
        start1  = 1'b1;
        start3  = 1'b1;
        cont    = 1'b0;
        ch_mask = 4'b1111;
        mux_in  = 4'd14;

        // Reset held 2 cycles with start asserted.
        step();
        step();
        chk("rst_sel", 32'(sel1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_word", 32'(word1), 0);
        chk("rst_cnt", 32'(cnt1), 0);
        chk("rst_busy3", 32'(busy3), 0);
        rst    = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy1), 0);

        // Basic scan, SETTLE=1, all channels, i=14.
        mux_in = 4'd14;
        ch_mask = 4'b1111;
        start1 = 1'b1;
        push1(4'b1110);
        step();
        start1 = 1'b0;
        chk("basic_sel0", 32'(sel1), 0);
        chk("basic_busy", 32'(busy1), 1);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("basic_sel", 32'(sel1), k);
            chk("basic_nodone", 32'(done1), 0);
        end
        step();
        chk("basic_done", 32'(done1), 1);
        chk("basic_busy_done", 32'(busy1), 1);
        step();
        chk("basic_done_fall", 32'(done1), 0);
        chk("basic_busy_fall", 32'(busy1), 0);
        chk("basic_sel_idle", 32'(sel1), 0);

        // Masked scan, SETTLE=3, mask 0101, i=7.
        mux_in  = 4'd7;
        ch_mask = 4'b0101;
        start3  = 1'b1;
        cnt3_m  = cnt3_m + 8'd1;
        q3.push_back('{word: 4'b0101, cnt: cnt3_m});
        step();
        start3  = 1'b0;
        ch_mask = 4'b1010;
        chk("mask_sel", 32'(sel3), 32'(exp_sel3[0]));
        for (int k = 1; k < 8; k++) begin
            step();
            chk("mask_sel", 32'(sel3), 32'(exp_sel3[k]));
            chk("mask_nodone", 32'(done3), 0);
        end
        step();
        chk("mask_done", 32'(done3), 1);
        step();
        chk("mask_busy_fall", 32'(busy3), 0);

        // Mid-scan input change and ignored start re-pulse.
        ch_mask = 4'b1111;
        mux_in  = 4'd2;
        start1  = 1'b1;
        push1(4'b1110);
        step();
        start1 = 1'b0;
        step();
        step();
        chk("mid_sel2", 32'(sel1), 2);
        mux_in = 4'd13;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        chk("mid_done", 32'(done1), 1);
        step();
        chk("mid_busy_fall", 32'(busy1), 0);
        step();
        step();
        chk("mid_still_idle", 32'(busy1), 0);

        // Reset during WAIT at sel=2.
        mux_in = 4'd9;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        step();
        chk("rstmid_sel2", 32'(sel1), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt1_m = 8'd0;
        chk("rstmid_sel", 32'(sel1), 0);
        chk("rstmid_busy", 32'(busy1), 0);
        chk("rstmid_done", 32'(done1), 0);
        chk("rstmid_word", 32'(word1), 0);
        chk("rstmid_cnt", 32'(cnt1), 0);
        step();
        step();
        chk("rstmid_nodone", 32'(done1), 0);
        mux_in = 4'b1011;
        start1 = 1'b1;
        push1(4'b1011);
        step();
        start1 = 1'b0;
        wait_done1(20, n);
        chk("rstmid_len", 32'(n), 4);
        step();
        chk("rstmid_idle", 32'(busy1), 0);

        // Continuous mode: 256 scans wrap the counter, cont dropped before the last DONE.
        mux_in = 4'b0110;
        cont   = 1'b1;
        start1 = 1'b1;
        push1(4'b0110);
        step();
        start1 = 1'b0;
        wait_done1(20, n);
        chk("cont_first_len", 32'(n), 4);
        for (int s = 1; s < 256; s++) begin
            push1(4'b0110);
            if (s == 255) begin
                step();
                cont = 1'b0;
                wait_done1(20, n);
                n++;
            end else begin
                wait_done1(20, n);
            end
            chk("cont_period", 32'(n), 5);
        end
        step();
        chk("cont_stop_busy", 32'(busy1), 0);
        chk("cont_stop_sel", 32'(sel1), 0);
        step();
        chk("cont_stop_done", 32'(done1), 0);
        chk("cont_stop_idle", 32'(busy1), 0);

        step();
        chk("sb1_empty", 32'(q1.size()), 0);
        chk("sb3_empty", 32'(q3.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
